// File: rtl/gpmc_wb_pkg.sv
// Shared types and defaults for the GPMC-to-Wishbone bridge.
// Holds the FSM state encoding and the default bus widths and error read data.
package gpmc_wb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WB_WR   = 2'd1,
    WB_RD   = 2'd2,
    RD_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/gpmc_wb_bridge_if.sv
// Wishbone classic single-master bus between the bridge and its downstream slave.
// A transfer completes on any clk edge where wbm_cyc, wbm_stb and wbm_ack are all 1;
// the master holds adr/dat_o/we stable while stb is high, the slave raises ack for one cycle.
interface gpmc_wb_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0] wbm_adr;
  logic [DATA_W-1:0] wbm_dat_o;
  logic [DATA_W-1:0] wbm_dat_i;
  logic              wbm_we;
  logic              wbm_cyc;
  logic              wbm_stb;
  logic              wbm_ack;

  modport master (
    output wbm_adr, wbm_dat_o, wbm_we, wbm_cyc, wbm_stb,
    input  wbm_dat_i, wbm_ack
  );

  modport slave (
    input  wbm_adr, wbm_dat_o, wbm_we, wbm_cyc, wbm_stb,
    output wbm_dat_i, wbm_ack
  );

endinterface

// File: rtl/gpmc_sync.sv
// N-stage flip-flop synchroniser for asynchronous GPMC inputs.
// Every bit shares the same stage count; the reset value is per instance.
module gpmc_sync #(
  parameter int             W       = 1,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= RST_VAL;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/gpmc_wb_bridge.sv
// GPMC multiplexed address/data bus to Wishbone master bridge.
// Strobes and AD are resynchronised into clk; each GPMC access becomes one Wishbone cycle.
module gpmc_wb_bridge
  import gpmc_wb_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                SYNC_STAGES = 2,
  parameter int                TIMEOUT     = 255,
  parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(ERR_DATA_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gpmc_csn,
  input  logic              gpmc_advn,
  input  logic              gpmc_oen,
  input  logic              gpmc_wen,
  input  logic [DATA_W-1:0] gpmc_ad_in,
  output logic [DATA_W-1:0] gpmc_ad_out,
  output logic              gpmc_ad_oe,
  gpmc_wb_bridge_if.master  wb,
  output logic              err_o,
  output state_t            fsm_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [3:0]        strb_s;
  logic [DATA_W-1:0] ad_s;
  logic              csn_s, advn_s, oen_s, wen_s;
  logic              oen_d, wen_d;
  logic              wen_rise, oen_fall;
  logic              wr_evt_q, rd_evt_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] wdat_q;
  logic [DATA_W-1:0] rdat_q;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] adr_r;
  logic [DATA_W-1:0] dat_r;
  logic              we_r, cyc_r, stb_r, err_r;

  gpmc_sync #(
    .W       (4),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (4'hF)
  ) u_sync_strb (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({gpmc_csn, gpmc_advn, gpmc_oen, gpmc_wen}),
    .q     (strb_s)
  );

  gpmc_sync #(
    .W       (DATA_W),
    .STAGES  (SYNC_STAGES),
    .RST_VAL ('0)
  ) u_sync_ad (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gpmc_ad_in),
    .q     (ad_s)
  );

  assign {csn_s, advn_s, oen_s, wen_s} = strb_s;

  // Reads are only accepted in the data phase; an OEN fall during ADVN is an illegal overlap.
  assign wen_rise = wen_s & ~wen_d & ~csn_s;
  assign oen_fall = ~oen_s & oen_d & ~csn_s & advn_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oen_d    <= 1'b1;
      wen_d    <= 1'b1;
      wr_evt_q <= 1'b0;
      rd_evt_q <= 1'b0;
      adr_q    <= '0;
      wdat_q   <= '0;
    end else begin
      oen_d    <= oen_s;
      wen_d    <= wen_s;
      wr_evt_q <= wen_rise;
      rd_evt_q <= oen_fall;
      if (!csn_s && !advn_s) adr_q <= ad_s[ADDR_W-1:0];
      if (wen_rise) wdat_q <= ad_s;
    end
  end

  // Events seen outside IDLE are simply not consumed; there is no queueing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      adr_r  <= '0;
      dat_r  <= '0;
      we_r   <= 1'b0;
      cyc_r  <= 1'b0;
      stb_r  <= 1'b0;
      err_r  <= 1'b0;
      rdat_q <= '0;
    end else begin
      err_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_evt_q) begin
            state <= WB_WR;
            cnt   <= '0;
            adr_r <= adr_q;
            dat_r <= wdat_q;
            we_r  <= 1'b1;
            cyc_r <= 1'b1;
            stb_r <= 1'b1;
          end else if (rd_evt_q) begin
            state <= WB_RD;
            cnt   <= '0;
            adr_r <= adr_q;
            dat_r <= wdat_q;
            we_r  <= 1'b0;
            cyc_r <= 1'b1;
            stb_r <= 1'b1;
          end
        end
        WB_WR, WB_RD: begin
          if (wb.wbm_ack) begin
            cyc_r <= 1'b0;
            stb_r <= 1'b0;
            we_r  <= 1'b0;
            if (state == WB_RD) begin
              rdat_q <= wb.wbm_dat_i;
              state  <= RD_HOLD;
            end else begin
              state <= IDLE;
            end
          end else if (cnt == CNT_LAST) begin
            cyc_r <= 1'b0;
            stb_r <= 1'b0;
            we_r  <= 1'b0;
            err_r <= 1'b1;
            if (state == WB_RD) begin
              rdat_q <= ERR_DATA;
              state  <= RD_HOLD;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RD_HOLD: begin
          if (oen_s || csn_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pad drive is gated by the live synchronised strobes so it releases in the same cycle.
  assign gpmc_ad_oe  = (state == RD_HOLD) && !oen_s && !csn_s && advn_s;
  assign gpmc_ad_out = rdat_q;

  assign wb.wbm_adr   = adr_r;
  assign wb.wbm_dat_o = dat_r;
  assign wb.wbm_we    = we_r;
  assign wb.wbm_cyc   = cyc_r;
  assign wb.wbm_stb   = stb_r;
  assign err_o        = err_r;
  assign fsm_state    = state;

endmodule
